counter_bcd_mod: RTL
====================

Name: counter_bcd_mod

Overview:
Parametrised multi-digit BCD modulo counter. It generalises the fixed hour counter into one block for seconds (00-59), minutes (00-59), 24-hour (00-23) and 12-hour (01-12) display counters. The block is fully synchronous to a single system clock. Counting is driven by a single-cycle carry-in enable, so instances cascade through cin/cout without ripple clocking. New behaviour over the hour counter: preset validation with an error flag, up/down adjust for manual time setting, and a configurable non-zero minimum value.

Parameters:
DIGITS, 2, number of BCD digits; value width is 4*DIGITS.
MIN_VAL, 0, lowest count value (decimal); wrap target when counting up.
MAX_VAL, 23, highest count value (decimal); must satisfy MIN_VAL < MAX_VAL < 10**DIGITS.

Ports:
clk  input  1  system clock; all state updates on rising edge
_CR  input  1  asynchronous active-low clear
cin  input  1  count enable; one step per clk edge where cin=1
up_dn  input  1  1 = count up, 0 = count down (adjust mode)
PE  input  1  synchronous preset enable
pre_val  input  4*DIGITS  BCD preset value, digit 0 = bits [3:0]
show_val  output  4*DIGITS  current BCD count, registered
cout  output  1  registered carry pulse on up-wrap
pre_err  output  1  registered one-cycle flag: preset rejected

Behaviour:
- Reset: _CR=0 forces, asynchronously, show_val = BCD(MIN_VAL), cout=0, pre_err=0. State is held while _CR=0. Reset mid-count discards the count and any pending pulse.
- Priority per clk edge: _CR > PE > cin. When PE=1, cin is ignored that cycle: no step and no cout.
- Preset validity: every nibble of pre_val <= 9 AND MIN_VAL <= decimal(pre_val) <= MAX_VAL.
  - Valid: show_val <= pre_val next edge; pre_err=0.
  - Invalid: show_val unchanged; pre_err=1 for exactly one cycle.
  - PE held high for N cycles loads or rejects every cycle; pre_err stays high each cycle an invalid value is presented.
- Up count (cin=1, up_dn=1):
  - show_val = BCD(MAX_VAL): next show_val = BCD(MIN_VAL) and cout=1.
  - Otherwise: BCD increment. A digit at 9 goes to 0 and carries to the next digit.
- Down count (cin=1, up_dn=0):
  - show_val = BCD(MIN_VAL): next show_val = BCD(MAX_VAL). cout stays 0; down-wrap never carries.
  - Otherwise: BCD decrement. A digit at 0 goes to 9 and borrows from the next digit.
- cout timing:
  - Asserted on the same edge the wrapped value appears; high for exactly one cycle.
  - Deasserted the next edge unless another up-wrap occurs.
- pre_err timing: registered; deasserts on the next edge without an invalid preset.
- cin held high continuously steps once per clock. With MIN_VAL = MAX_VAL-1 this gives a wrap every 2 cycles and cout high every other cycle.
- cin=0 and PE=0: show_val holds; cout=0; pre_err=0.
- Out-of-range state: if show_val is ever outside [MIN_VAL, MAX_VAL] or holds a non-BCD nibble, the next cin step loads BCD(MIN_VAL). This cannot arise after reset and is defined for robustness only.
- Arithmetic: digit-wise BCD only. The comparison against MIN_VAL/MAX_VAL uses elaboration-time BCD constants, with no binary intermediate.
- Cascade: a seconds instance's cout drives the minutes instance's cin, and so on. All instances share clk and _CR.

Test Plan:
1. Default (00-23). _CR=0 for 2 cycles, then release; hold cin=1, up_dn=1 for 25 clocks -> show_val steps 0x00,0x01..0x09,0x10..0x23,0x00,0x01. cout=1 only in the cycle show_val=0x00 after 0x23.
2. Preset rejection. PE=1 with pre_val=0x55 -> show_val unchanged, pre_err=1 for one cycle. PE=1 with pre_val=0x1A -> rejected (nibble>9), pre_err=1. PE=1 with pre_val=0x19 -> show_val=0x19, pre_err=0. Then cin=1 -> 0x20.
3. 12-hour instance (MIN_VAL=1, MAX_VAL=12). Preset 0x11, cin=1 for 3 clocks -> 0x12, 0x01 with cout=1, then 0x02. Preset 0x00 -> rejected, pre_err=1.
4. Down adjust, default instance. Preset 0x10; up_dn=0, cin=1 for 12 clocks -> 0x09..0x00, 0x23, 0x22. cout stays 0 throughout.
5. Simultaneous events. show_val=0x23, PE=1 with pre_val=0x05 and cin=1 in the same cycle -> show_val=0x05, cout=0. Then assert _CR asynchronously mid-cycle while cin=1 -> show_val=0x00 immediately, cout=0.
6. Cascade. Instance 00-59 drives the cin of a 00-23 instance; preset 0x59/0x23, one cin pulse -> both show 0x00. The 00-59 cout pulses for one cycle; the 00-23 cout rises one cycle later, because it steps on the edge after seeing that cout.

Source files
------------

// File: rtl/counter_bcd_mod_if.sv
// Control and display bundle of the BCD modulo counter.
// The master side drives the step, adjust and preset controls. The slave side returns the count and its flags.
interface counter_bcd_mod_if #(
   parameter int DIGITS = 2
) ();
   logic                  cin;
   logic                  up_dn;
   logic                  PE;
   logic [4*DIGITS-1:0]   pre_val;
   logic [4*DIGITS-1:0]   show_val;
   logic                  cout;
   logic                  pre_err;

   modport master (
      output cin, up_dn, PE, pre_val,
      input  show_val, cout, pre_err
   );

   modport slave (
      input  cin, up_dn, PE, pre_val,
      output show_val, cout, pre_err
   );
endinterface

// File: rtl/counter_bcd_mod.sv
// Multi-digit BCD modulo counter with a range of [MIN_VAL, MAX_VAL].
// It supports a validated preset, up/down stepping and a carry pulse on up-wrap, so instances can be cascaded.
module counter_bcd_mod #(
   parameter int DIGITS  = 2,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = 23
) (
   input  logic             clk,
   input  logic             _CR,
   counter_bcd_mod_if.slave bus
);
   localparam int W = 4 * DIGITS;

   function automatic logic [W-1:0] to_bcd(input int v);
      int             n;
      logic [W-1:0]   r;
      n = v;
      r = {W{1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(n % 10);
         n           = n / 10;
      end
      return r;
   endfunction

   function automatic logic is_bcd(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            ok = 1'b0;
         end else begin
            ok = ok;
         end
      end
      return ok;
   endfunction

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!c) begin
            r[4*i +: 4] = v[4*i +: 4];
         end else if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
         end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c           = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!b) begin
            r[4*i +: 4] = v[4*i +: 4];
         end else if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
         end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            b           = 1'b0;
         end
      end
      return r;
   endfunction

   localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
   localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

   logic [W-1:0] count_r;
   logic         cout_r;
   logic         err_r;
   logic [W-1:0] count_nxt_s;
   logic         cout_nxt_s;
   logic         err_nxt_s;
   logic         pre_ok_s;
   logic         state_ok_s;

   // For valid BCD operands, a plain vector compare orders the values exactly like their decimal values.
   always_comb begin
      pre_ok_s   = is_bcd(bus.pre_val) && (bus.pre_val >= MIN_BCD) && (bus.pre_val <= MAX_BCD);
      state_ok_s = is_bcd(count_r) && (count_r >= MIN_BCD) && (count_r <= MAX_BCD);
   end

   // Next-state selection with priority preset > step > hold.
   always_comb begin
      count_nxt_s = count_r;
      cout_nxt_s  = 1'b0;
      err_nxt_s   = 1'b0;
      if (bus.PE) begin
         if (pre_ok_s) begin
            count_nxt_s = bus.pre_val;
         end else begin
            err_nxt_s   = 1'b1;
         end
      end else if (bus.cin) begin
         if (!state_ok_s) begin
            count_nxt_s = MIN_BCD;
         end else if (bus.up_dn) begin
            if (count_r == MAX_BCD) begin
               count_nxt_s = MIN_BCD;
               cout_nxt_s  = 1'b1;
            end else begin
               count_nxt_s = bcd_inc(count_r);
            end
         end else begin
            if (count_r == MIN_BCD) begin
               count_nxt_s = MAX_BCD;
            end else begin
               count_nxt_s = bcd_dec(count_r);
            end
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Count and flag registers, with asynchronous clear.
   always_ff @(posedge clk or negedge _CR) begin
      if (!_CR) begin
         count_r <= MIN_BCD;
         cout_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         cout_r  <= cout_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   assign bus.show_val = count_r;
   assign bus.cout     = cout_r;
   assign bus.pre_err  = err_r;
endmodule
